// File: rtl/sync_pkt_fifo_pkg.sv
// Shared types and default parameters for the packet-aware synchronous FIFO.
// Contents:
//   wr_state_t      - write-side FSM states
//   DEF_*           - default parameter values used by the interface and top
package sync_pkt_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_AFULL_LEVEL  = 248;
    localparam int unsigned DEF_AEMPTY_LEVEL = 8;
    localparam int unsigned DEF_LOOKAHEAD    = 0;

    typedef enum logic [1:0] {
        WS_IDLE    = 2'd0,
        WS_OPEN    = 2'd1,
        WS_DISCARD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sync_pkt_fifo_if.sv
// Bundle of write, read and status signals of sync_pkt_fifo.
// Ports (modport slave = FIFO side, master = producer/consumer side):
//   data_in, wr_en, wr_eop, wr_drop  - write side
//   rd_en                            - read request
//   data_out, rd_eop                 - read data and its eop flag
//   empty, full, afull, aempty       - status flags
//   uw, pkt_cnt                      - committed words / committed packets
//   drop_ovf                         - overflow discard pulse
interface sync_pkt_fifo_if
    import sync_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  wr_eop;
    logic                  wr_drop;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_eop;
    logic                  empty;
    logic                  full;
    logic                  afull;
    logic                  aempty;
    logic [ADDR_WIDTH:0]   uw;
    logic [ADDR_WIDTH:0]   pkt_cnt;
    logic                  drop_ovf;

    modport master (
        output data_in, wr_en, wr_eop, wr_drop, rd_en,
        input  data_out, rd_eop, empty, full, afull, aempty, uw, pkt_cnt, drop_ovf
    );

    modport slave (
        input  data_in, wr_en, wr_eop, wr_drop, rd_en,
        output data_out, rd_eop, empty, full, afull, aempty, uw, pkt_cnt, drop_ovf
    );

endinterface

// File: rtl/sync_pkt_fifo_ram.sv
// Simple dual-port storage for sync_pkt_fifo; word = {eop, data}.
// Ports:
//   clk            - clock
//   clr            - clears the registered read output (LOOKAHEAD=0 only)
//   we/waddr/wdata - synchronous write port
//   re/raddr       - read port; registered on re when LOOKAHEAD=0, async otherwise
//   rdata          - read word
//   head_eop       - eop bit at raddr, always combinational (packet accounting)
module sync_pkt_fifo_ram #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LOOKAHEAD  = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata,
    output logic                  head_eop
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign head_eop = mem[raddr][WIDTH-1];

    generate
        if (LOOKAHEAD == 0) begin : g_reg_rd
            // Registered read: loads only on an accepted read, holds otherwise.
            always_ff @(posedge clk) begin
                if (clr) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async_rd
            assign rdata = mem[raddr];
            logic unused_ctl;
            assign unused_ctl = clr ^ re;
        end
    endgenerate

endmodule

// File: rtl/sync_pkt_fifo.sv
// Packet-aware synchronous FIFO: words are written speculatively and become
// readable only when the packet's eop word is written; abort or overflow
// rewinds the speculative pointer so partial packets never reach the reader.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   sclr  - synchronous clear, same effect as rst
//   bus   - sync_pkt_fifo_if.slave (write/read handshakes, flags, counters)
module sync_pkt_fifo
    import sync_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned AFULL_LEVEL  = DEF_AFULL_LEVEL,
    parameter int unsigned AEMPTY_LEVEL = DEF_AEMPTY_LEVEL,
    parameter int unsigned LOOKAHEAD    = DEF_LOOKAHEAD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sclr,
    sync_pkt_fifo_if.slave bus
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned MW    = DATA_WIDTH + 1;

    wr_state_t       state, state_n;
    logic [PW-1:0]   wr_spec, wr_spec_n;
    logic [PW-1:0]   wr_com, wr_com_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [PW-1:0]   pkt_r, pkt_n;
    logic [PW-1:0]   uw_r;
    logic [PW-1:0]   spec_occ_n, com_occ_n;
    logic            full_r, empty_r, afull_r, aempty_r, ovf_r, ovf_n;
    logic            mem_we, commit, rd_acc, head_eop, clr;
    logic [MW-1:0]   ram_q;

    assign clr = rst | sclr;

    // Write FSM, read acceptance and next pointer/counter values.
    always_comb begin
        state_n   = state;
        wr_spec_n = wr_spec;
        wr_com_n  = wr_com;
        ovf_n     = 1'b0;
        mem_we    = 1'b0;
        commit    = 1'b0;

        case (state)
            WS_IDLE, WS_OPEN: begin
                if (bus.wr_drop) begin
                    // Abort wins over a same-cycle write; no-op when idle.
                    wr_spec_n = wr_com;
                    state_n   = WS_IDLE;
                end else if (bus.wr_en) begin
                    if (full_r) begin
                        // Overflow: throw away the whole open packet.
                        wr_spec_n = wr_com;
                        if (bus.wr_eop) begin
                            ovf_n   = 1'b1;
                            state_n = WS_IDLE;
                        end else begin
                            state_n = WS_DISCARD;
                        end
                    end else begin
                        mem_we    = 1'b1;
                        wr_spec_n = wr_spec + PW'(1);
                        if (bus.wr_eop) begin
                            wr_com_n = wr_spec + PW'(1);
                            commit   = 1'b1;
                            state_n  = WS_IDLE;
                        end else begin
                            state_n  = WS_OPEN;
                        end
                    end
                end
            end
            WS_DISCARD: begin
                wr_spec_n = wr_com;
                if (bus.wr_drop) begin
                    state_n = WS_IDLE;
                end else if (bus.wr_en && bus.wr_eop) begin
                    ovf_n   = 1'b1;
                    state_n = WS_IDLE;
                end
            end
            default: begin
                wr_spec_n = wr_com;
                state_n   = WS_IDLE;
            end
        endcase

        rd_acc     = bus.rd_en & ~empty_r;
        rd_ptr_n   = rd_ptr + PW'(rd_acc);
        pkt_n      = pkt_r + PW'(commit) - PW'(rd_acc & head_eop);
        spec_occ_n = wr_spec_n - rd_ptr_n;
        com_occ_n  = wr_com_n - rd_ptr_n;
    end

    // State, pointers and registered flags (flags track the new pointers).
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= WS_IDLE;
            wr_spec  <= '0;
            wr_com   <= '0;
            rd_ptr   <= '0;
            pkt_r    <= '0;
            uw_r     <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            state    <= state_n;
            wr_spec  <= wr_spec_n;
            wr_com   <= wr_com_n;
            rd_ptr   <= rd_ptr_n;
            pkt_r    <= pkt_n;
            uw_r     <= com_occ_n;
            full_r   <= (spec_occ_n == PW'(DEPTH));
            empty_r  <= (com_occ_n == '0);
            afull_r  <= (spec_occ_n >= PW'(AFULL_LEVEL));
            aempty_r <= (com_occ_n <= PW'(AEMPTY_LEVEL));
            ovf_r    <= ovf_n;
        end
    end

    sync_pkt_fifo_ram #(
        .WIDTH      (MW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LOOKAHEAD  (LOOKAHEAD)
    ) u_ram (
        .clk      (clk),
        .clr      (clr),
        .we       (mem_we),
        .waddr    (wr_spec[ADDR_WIDTH-1:0]),
        .wdata    ({bus.wr_eop, bus.data_in}),
        .re       (rd_acc),
        .raddr    (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata    (ram_q),
        .head_eop (head_eop)
    );

    generate
        if (LOOKAHEAD != 0) begin : g_show_ahead
            // Head word is visible only while committed data exists.
            assign bus.data_out = empty_r ? '0 : ram_q[DATA_WIDTH-1:0];
            assign bus.rd_eop   = ~empty_r & ram_q[DATA_WIDTH];
        end else begin : g_registered
            assign bus.data_out = ram_q[DATA_WIDTH-1:0];
            assign bus.rd_eop   = ram_q[DATA_WIDTH];
        end
    endgenerate

    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
    assign bus.afull    = afull_r;
    assign bus.aempty   = aempty_r;
    assign bus.uw       = uw_r;
    assign bus.pkt_cnt  = pkt_r;
    assign bus.drop_ovf = ovf_r;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Bench for sync_pkt_fifo: a registered-read and a show-ahead instance
// (16 words each) share one stimulus stream and one queue-based model.
module tb_sync_pkt_fifo;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 4;
    localparam int          DEPTH  = 16;
    localparam int          AFULL  = 12;
    localparam int          AEMPTY = 2;

    logic          clk = 1'b0;
    logic          rst, sclr;
    logic [DW-1:0] data_in;
    logic          wr_en, wr_eop, wr_drop, rd_en;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    sync_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    assign if0.data_in = data_in;
    assign if0.wr_en   = wr_en;
    assign if0.wr_eop  = wr_eop;
    assign if0.wr_drop = wr_drop;
    assign if0.rd_en   = rd_en;
    assign if1.data_in = data_in;
    assign if1.wr_en   = wr_en;
    assign if1.wr_eop  = wr_eop;
    assign if1.wr_drop = wr_drop;
    assign if1.rd_en   = rd_en;

    sync_pkt_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL),
        .AEMPTY_LEVEL(AEMPTY), .LOOKAHEAD(0)
    ) dut0 (.clk(clk), .rst(rst), .sclr(sclr), .bus(if0));

    sync_pkt_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL),
        .AEMPTY_LEVEL(AEMPTY), .LOOKAHEAD(1)
    ) dut1 (.clk(clk), .rst(rst), .sclr(sclr), .bus(if1));

    // ---------------- model: committed queue + open packet ----------------
    logic [DW:0]   cq[$];
    logic [DW:0]   oq[$];
    bit            discarding;
    logic [DW-1:0] e_dout;
    logic          e_eop;
    logic          e_ovf;

    always @(posedge clk) begin : p_model
        bit          full_now;
        bit          empty_now;
        logic [DW:0] w;
        if (rst || sclr) begin
            cq.delete();
            oq.delete();
            discarding = 1'b0;
            e_dout     = '0;
            e_eop      = 1'b0;
            e_ovf      = 1'b0;
        end else begin
            full_now  = (cq.size() + oq.size()) == DEPTH;
            empty_now = (cq.size() == 0);
            e_ovf     = 1'b0;
            if (rd_en && !empty_now) begin
                w      = cq.pop_front();
                e_dout = w[DW-1:0];
                e_eop  = w[DW];
            end
            if (wr_drop) begin
                oq.delete();
                discarding = 1'b0;
            end else if (wr_en) begin
                if (discarding) begin
                    if (wr_eop) begin
                        discarding = 1'b0;
                        e_ovf      = 1'b1;
                    end
                end else if (full_now) begin
                    oq.delete();
                    if (wr_eop) e_ovf = 1'b1;
                    else        discarding = 1'b1;
                end else begin
                    oq.push_back({wr_eop, data_in});
                    if (wr_eop) begin
                        foreach (oq[i]) cq.push_back(oq[i]);
                        oq.delete();
                    end
                end
            end
        end
    end

    function automatic int eop_count();
        int n = 0;
        foreach (cq[i]) if (cq[i][DW]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin : p_cmp
        int            occ;
        int            com;
        logic [DW-1:0] la_d;
        logic          la_e;
        if (chk_en) begin
            com  = cq.size();
            occ  = cq.size() + oq.size();
            la_d = (com > 0) ? cq[0][DW-1:0] : '0;
            la_e = (com > 0) ? cq[0][DW] : 1'b0;
            chk("d0_empty",  64'(if0.empty),    64'(com == 0));
            chk("d0_full",   64'(if0.full),     64'(occ == DEPTH));
            chk("d0_afull",  64'(if0.afull),    64'(occ >= AFULL));
            chk("d0_aempty", 64'(if0.aempty),   64'(com <= AEMPTY));
            chk("d0_uw",     64'(if0.uw),       64'(com));
            chk("d0_pkt",    64'(if0.pkt_cnt),  64'(eop_count()));
            chk("d0_ovf",    64'(if0.drop_ovf), 64'(e_ovf));
            chk("d0_dout",   64'(if0.data_out), 64'(e_dout));
            chk("d0_rdeop",  64'(if0.rd_eop),   64'(e_eop));
            chk("d1_empty",  64'(if1.empty),    64'(com == 0));
            chk("d1_uw",     64'(if1.uw),       64'(com));
            chk("d1_pkt",    64'(if1.pkt_cnt),  64'(eop_count()));
            chk("d1_ovf",    64'(if1.drop_ovf), 64'(e_ovf));
            chk("d1_dout",   64'(if1.data_out), 64'(la_d));
            chk("d1_rdeop",  64'(if1.rd_eop),   64'(la_e));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cyc(input bit we, input bit eop, input bit drop, input bit re,
                       input logic [DW-1:0] d, input bit c_sclr, input bit c_rst);
        wr_en   = we;
        wr_eop  = eop;
        wr_drop = drop;
        rd_en   = re;
        data_in = d;
        sclr    = c_sclr;
        rst     = c_rst;
        @(negedge clk);
    endtask

    task automatic wr(input logic [DW-1:0] d, input bit eop);
        cyc(1'b1, eop, 1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sclr = 1'b0; data_in = '0;
        wr_en = 1'b0; wr_eop = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset values
        idle();
        chk("rst_empty", 64'(if0.empty), 64'd1);
        chk("rst_uw",    64'(if0.uw),    64'd0);
        chk("rst_dout",  64'(if0.data_out), 64'd0);

        // Basic packet 0x11..0x14
        wr(32'h11, 1'b0); chk("p1_empty_w1", 64'(if0.empty), 64'd1);
        wr(32'h12, 1'b0); chk("p1_empty_w2", 64'(if0.empty), 64'd1);
        wr(32'h13, 1'b0); chk("p1_empty_w3", 64'(if0.empty), 64'd1);
        wr(32'h14, 1'b1);
        chk("p1_empty", 64'(if0.empty),   64'd0);
        chk("p1_uw",    64'(if0.uw),      64'd4);
        chk("p1_pkt",   64'(if0.pkt_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            rd();
            chk("p1_rd_data", 64'(if0.data_out), 64'(32'h11 + i));
            chk("p1_rd_eop",  64'(if0.rd_eop),   64'(i == 3));
        end
        chk("p1_end_empty", 64'(if0.empty),   64'd1);
        chk("p1_end_pkt",   64'(if0.pkt_cnt), 64'd0);

        // Abort with a same-cycle write
        wr(32'h21, 1'b0); wr(32'h22, 1'b0); wr(32'h23, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h24, 1'b0, 1'b0);
        chk("drop_uw",    64'(if0.uw),    64'd0);
        chk("drop_empty", 64'(if0.empty), 64'd1);
        wr(32'hA0, 1'b0); wr(32'hA1, 1'b1);
        chk("drop_uw2", 64'(if0.uw), 64'd2);
        rd(); chk("drop_rd0", 64'(if0.data_out), 64'hA0);
        rd(); chk("drop_rd1", 64'(if0.data_out), 64'hA1);
        idle();
        chk("drop_end_empty", 64'(if0.empty), 64'd1);

        // 20-word packet overflows a 16-word FIFO
        for (int i = 1; i <= 20; i++) begin
            wr(32'h100 + 32'(i), i == 20);
            if (i == 16) chk("ovf_full16", 64'(if0.full), 64'd1);
            if (i == 20) chk("ovf_pulse",  64'(if0.drop_ovf), 64'd1);
        end
        idle();
        chk("ovf_pulse_end", 64'(if0.drop_ovf), 64'd0);
        chk("ovf_uw",   64'(if0.uw),      64'd0);
        chk("ovf_full", 64'(if0.full),    64'd0);
        chk("ovf_pkt",  64'(if0.pkt_cnt), 64'd0);

        // Exactly full, then overflowing 1-word packet with a same-cycle read
        for (int i = 0; i < 16; i++) wr(32'h400 + 32'(i), i == 15);
        chk("fr_full", 64'(if0.full), 64'd1);
        chk("fr_uw",   64'(if0.uw),   64'd16);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h4FF, 1'b0, 1'b0);
        chk("fr_ovf",  64'(if0.drop_ovf), 64'd1);
        chk("fr_dout", 64'(if0.data_out), 64'h400);
        chk("fr_uw15", 64'(if0.uw),       64'd15);
        repeat (15) rd();
        chk("fr_last",     64'(if0.data_out), 64'h40F);
        chk("fr_last_eop", 64'(if0.rd_eop),   64'd1);
        chk("fr_empty",    64'(if0.empty),    64'd1);

        // Preloaded 10-word packet, then streaming 1-word packets with reads
        for (int i = 0; i < 10; i++) wr(32'h200 + 32'(i), i == 9);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
            chk("strm_uw", 64'(if0.uw), 64'd10);
        end
        chk("strm_pkt", 64'(if0.pkt_cnt), 64'd10);
        repeat (10) rd();
        chk("strm_last",  64'(if0.data_out), 64'h327);
        chk("strm_empty", 64'(if0.empty),    64'd1);
        chk("strm_pkt0",  64'(if0.pkt_cnt),  64'd0);

        // Show-ahead: head visible without rd_en, popped by rd_en
        wr(32'h55, 1'b1);
        chk("la_dout", 64'(if1.data_out), 64'h55);
        chk("la_eop",  64'(if1.rd_eop),   64'd1);
        rd();
        chk("la_empty",  64'(if1.empty),    64'd1);
        chk("la_dout0",  64'(if1.data_out), 64'd0);
        chk("la_d0dout", 64'(if0.data_out), 64'h55);

        // sclr during the 5th write of an open packet
        for (int i = 0; i < 4; i++) wr(32'h71 + 32'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h75, 1'b1, 1'b0);
        chk("sclr_uw",    64'(if0.uw),       64'd0);
        chk("sclr_empty", 64'(if0.empty),    64'd1);
        chk("sclr_dout",  64'(if0.data_out), 64'd0);
        wr(32'h61, 1'b0); wr(32'h62, 1'b1);
        rd(); chk("sclr_rd0", 64'(if0.data_out), 64'h61);
        rd(); chk("sclr_rd1", 64'(if0.data_out), 64'h62);

        // rst during a read sequence
        wr(32'h81, 1'b0); wr(32'h82, 1'b0); wr(32'h83, 1'b1);
        rd(); chk("rst_rd0", 64'(if0.data_out), 64'h81);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1);
        chk("rstm_dout",  64'(if0.data_out), 64'd0);
        chk("rstm_uw",    64'(if0.uw),       64'd0);
        chk("rstm_empty", 64'(if0.empty),    64'd1);
        chk("rstm_pkt",   64'(if0.pkt_cnt),  64'd0);
        wr(32'h91, 1'b1);
        rd();
        chk("rstm_rd",  64'(if0.data_out), 64'h91);
        chk("rstm_eop", 64'(if0.rd_eop),   64'd1);
        idle();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
